// File: rtl/i2c_master_write_sequencer_if.sv
// Bundle of the host, engine, ACK-stage and status signals around the
// I2C write sequencer. The master modport is the sequencer's view; the
// slave modport is the view of whatever surrounds it (host, engine, ACK stage).
interface i2c_master_write_sequencer_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       go;
  logic [2:0] command;
  logic       data;
  logic       load;
  logic       finish;
  logic       ack_req;
  logic       ack_done;
  logic       ack_nack;
  logic       busy;
  logic       done;
  logic       nack_err;
  logic       timeout_err;

  modport master (
    input  start, addr, tx_data, tx_valid, tx_last, load, finish, ack_done, ack_nack,
    output tx_ready, go, command, data, ack_req, busy, done, nack_err, timeout_err
  );

  modport slave (
    output start, addr, tx_data, tx_valid, tx_last, load, finish, ack_done, ack_nack,
    input  tx_ready, go, command, data, ack_req, busy, done, nack_err, timeout_err
  );
endinterface

// File: rtl/i2c_master_write_sequencer.sv
// Transaction-level I2C write master: START, address byte, data bytes, STOP,
// driven through the bit engine's go/finish handshake with per-byte ACK checks.
// Optional watchdog on every handshake wait: define I2C_SEQ_TIMEOUT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start
//   START   | engine executing CMD_START
//   ADDR    | engine shifting out {addr,0}
//   ACK     | waiting for the ACK stage verdict on the last byte
//   FETCH   | tx_ready high, waiting for the next host byte
//   DATA    | engine shifting out a data byte
//   STOP    | engine executing CMD_STOP
//   WAITLOW | go dropped, waiting for finish to return low, then ret_q
//   DONE    | one-cycle done pulse
module i2c_master_write_sequencer #(
  parameter logic [2:0]  CMD_START      = 3'b001,
  parameter logic [2:0]  CMD_DATA       = 3'b011,
  parameter logic [2:0]  CMD_STOP       = 3'b100,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                          clock,
  input logic                          reset_n,
  i2c_master_write_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK, FETCH, DATA, STOP, WAITLOW, DONE
  } state_t;

  state_t     state, state_nxt;
  state_t     ret_q, ret_nxt;
  logic [6:0] addr_q;
  logic [7:0] shreg;
  logic       last_q;
  logic       nack_q;
  logic       go_c, ack_req_c, tx_ready_c, done_c;
  logic [2:0] cmd_c;
  logic       capture, accept, set_nack;
  logic       timeout_hit;

  // State and return-state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ret_q <= IDLE;
    end else begin
      state <= state_nxt;
      ret_q <= ret_nxt;
    end
  end

  // Next-state and handshake outputs; go/ack_req/tx_ready follow the state
  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_q;
    go_c       = 1'b0;
    cmd_c      = 3'b000;
    ack_req_c  = 1'b0;
    tx_ready_c = 1'b0;
    done_c     = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    set_nack   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        go_c  = 1'b1;
        cmd_c = CMD_START;
        if (bus.finish) begin
          state_nxt = WAITLOW;
          ret_nxt   = ADDR;
        end
      end
      ADDR, DATA: begin
        go_c  = 1'b1;
        cmd_c = CMD_DATA;
        if (bus.finish) begin
          state_nxt = WAITLOW;
          ret_nxt   = ACK;
        end
      end
      ACK: begin
        ack_req_c = 1'b1;
        if (bus.ack_done) begin
          if (bus.ack_nack) begin
            set_nack  = 1'b1;
            state_nxt = STOP;
          end else if (last_q) begin
            state_nxt = STOP;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        tx_ready_c = 1'b1;
        if (bus.tx_valid) begin
          accept    = 1'b1;
          state_nxt = DATA;
        end
      end
      STOP: begin
        go_c  = 1'b1;
        cmd_c = CMD_STOP;
        if (bus.finish) begin
          state_nxt = WAITLOW;
          ret_nxt   = DONE;
        end
      end
      WAITLOW: begin
        if (!bus.finish) state_nxt = ret_q;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A watchdog abort drops go immediately and passes through WAITLOW so
    // the STOP command starts with a fresh low-to-high go edge.
    if (timeout_hit) begin
      go_c       = 1'b0;
      ack_req_c  = 1'b0;
      tx_ready_c = 1'b0;
      accept     = 1'b0;
      set_nack   = 1'b0;
      if (state == STOP) begin
        state_nxt = DONE;
      end else begin
        state_nxt = WAITLOW;
        ret_nxt   = STOP;
      end
    end
  end

  // Address capture, byte loading and MSB-first shifting on engine strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= 7'h00;
      shreg  <= 8'h00;
      last_q <= 1'b0;
    end else begin
      if (capture) begin
        addr_q <= bus.addr;
        last_q <= 1'b0;
      end
      if (state_nxt == ADDR && state != ADDR) begin
        shreg <= {addr_q, 1'b0};
      end else if (accept) begin
        shreg  <= bus.tx_data;
        last_q <= bus.tx_last;
      end else if ((state == ADDR || state == DATA) && !bus.load) begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

  // Sticky NACK flag, cleared when the next transaction is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      nack_q <= 1'b0;
    else if (capture)  nack_q <= 1'b0;
    else if (set_nack) nack_q <= 1'b1;
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;
  logic          waiting;
  logic          tout_q;

  assign waiting = ((state == START || state == ADDR || state == DATA || state == STOP) && !bus.finish) ||
                   (state == ACK   && !bus.ack_done) ||
                   (state == FETCH && !bus.tx_valid);
  assign timeout_hit = (wd_cnt == TW'(TIMEOUT_CYCLES));

  // Watchdog: restarts on every state change and on every bit strobe, so a
  // long but progressing byte transfer is not mistaken for a hung engine
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state_nxt != state || ((state == ADDR || state == DATA) && !bus.load)) begin
      wd_cnt <= '0;
    end else if (waiting && !timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared when the next transaction is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         tout_q <= 1'b0;
    else if (capture)     tout_q <= 1'b0;
    else if (timeout_hit) tout_q <= 1'b1;
  end

  assign bus.timeout_err = tout_q;
`else
  // Watchdog compiled out: every wait is unbounded and the limit has no effect
  assign timeout_hit     = 1'b0 & (TIMEOUT_CYCLES == 0);
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.go       = go_c;
  assign bus.command  = cmd_c;
  assign bus.data     = shreg[7];
  assign bus.ack_req  = ack_req_c;
  assign bus.tx_ready = tx_ready_c;
  assign bus.busy     = (state != IDLE) && (state != DONE);
  assign bus.done     = done_c;
  assign bus.nack_err = nack_q;

endmodule
